// File: rtl/io_uart_console.sv
// io_uart_console: memory-mapped console on the CPU data bus.
// Characters written to CHAR are queued in a FIFO and sent on txd as 8N1 frames.
// HLT sets a sticky halt flag. STATUS reports FIFO state, TX activity and the halt flag.

package io_uart_console_pkg;
    // Bus access-type encoding; mirrors the DataBus.vh encoding used by the CPU.
    localparam logic [1:0] MEM_ACCESS_NONE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_R    = 2'd1;
    localparam logic [1:0] MEM_ACCESS_W    = 2'd2;
    localparam logic [1:0] MEM_ACCESS_X    = 2'd3;

    localparam logic [31:0] ADDR_HLT    = 32'h0000_0000;
    localparam logic [31:0] ADDR_CHAR   = 32'h0000_0001;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0002;
endpackage

module io_uart_console
    import io_uart_console_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 868
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        db_io,
    input  logic [1:0]                  db_accessType,
    input  logic [31:0]                 db_addr,
    input  logic [31:0]                 db_dataOut,
    output logic [31:0]                 db_dataIn,
    output logic                        db_ready,
    output logic                        hlt,
    output logic                        txd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Registered state
    logic             r_hlt;
    logic [31:0]      r_data_in;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    tx_state_t        r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_txd;

    // Combinational signals
    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_baud_last;
    logic [7:0]  w_head;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;
    logic        w_unused;

    // Only the low byte of write data is ever stored.
    assign w_unused = ^db_dataOut[31:8];

    // Bus qualification; everything is ignored while reset is held.
    assign w_sel = !res && db_io &&
                   (db_accessType == MEM_ACCESS_R || db_accessType == MEM_ACCESS_W);
    assign w_wr  = w_sel && (db_accessType == MEM_ACCESS_W);
    assign w_rd  = w_sel && (db_accessType == MEM_ACCESS_R);

    assign w_fifo_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_baud_last  = (r_baud == CNT_W'(CLK_DIV - 1));

    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous TX pop never lets a blocked write through early.
    assign w_push   = w_wr && (db_addr == ADDR_CHAR) && !w_fifo_full;
    assign db_ready = !(w_wr && (db_addr == ADDR_CHAR) && w_fifo_full);

    // The transmitter takes a character when idle, or back-to-back at the end of STOP.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || (r_state == ST_STOP && w_baud_last));

    // Status word and read-data selection.
    // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_status       = '0;
        w_status[0]    = w_fifo_empty;
        w_status[1]    = w_fifo_full;
        w_status[2]    = (r_state != ST_IDLE);
        w_status[3]    = r_hlt;
        w_status[15:8] = 8'(r_count);
        w_rd_data      = (db_addr == ADDR_STATUS) ? w_status : '0;
    end

    // Halt flag and registered read data.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            r_hlt     <= 1'b0;
            r_data_in <= '0;
        end else begin
            if (w_wr && (db_addr == ADDR_HLT))
                r_hlt <= 1'b1;
            if (w_rd)
                r_data_in <= w_rd_data;
        end
    end

    // Character storage.
    // NOTE: the array is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= db_dataOut[7:0];
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // UART transmitter: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_txd  <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= ST_START;
                        r_txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign db_dataIn  = r_data_in;
    assign hlt        = r_hlt;
    assign txd        = r_txd;
    assign fifo_level = r_count;

endmodule

// File: tb/tb_io_uart_console.sv
// tb_io_uart_console: directed bench for the console, FIFO_DEPTH=4, CLK_DIV=4.
// Inputs change on the falling edge; outputs are sampled #1 after the rising edge.

`timescale 1ns/1ps

module tb_io_uart_console;
    import io_uart_console_pkg::*;

    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        res;
    logic        db_io;
    logic [1:0]  db_accessType;
    logic [31:0] db_addr;
    logic [31:0] db_dataOut;
    logic [31:0] db_dataIn;
    logic        db_ready;
    logic        hlt;
    logic        txd;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Frame receiver state
    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_ok[$];

    io_uart_console #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .clk           (clk),
        .res           (res),
        .db_io         (db_io),
        .db_accessType (db_accessType),
        .db_addr       (db_addr),
        .db_dataOut    (db_dataOut),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .hlt           (hlt),
        .txd           (txd),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        db_io         = 1'b0;
        db_accessType = MEM_ACCESS_NONE;
        db_addr       = '0;
        db_dataOut    = '0;
    endtask

    // Write, retrying while db_ready is low; reports the number of stalled cycles.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output int stalls);
        stalls = 0;
        @(negedge clk);
        db_io         = 1'b1;
        db_accessType = MEM_ACCESS_W;
        db_addr       = a;
        db_dataOut    = d;
        #1;
        while (db_ready !== 1'b1 && stalls < 500) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 500) check("wr_timeout", db_ready, 1);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic rdy);
        @(negedge clk);
        db_io         = 1'b1;
        db_accessType = MEM_ACCESS_R;
        db_addr       = a;
        #1;
        rdy = db_ready;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    // Frame receiver: locks on the first low cycle, samples mid-bit (cycle 4*b+2).
    always begin : rx_mon
        logic [7:0] sh;
        logic       ok;
        int         t0;
        @(negedge clk);
        if (rx_en && txd === 1'b0) begin
            t0 = cyc;
            ok = 1'b1;
            repeat (2) @(negedge clk);
            if (txd !== 1'b0) ok = 1'b0;
            for (int b = 0; b < 8; b++) begin
                repeat (4) @(negedge clk);
                sh[b] = txd;
            end
            repeat (4) @(negedge clk);
            if (txd !== 1'b1) ok = 1'b0;
            repeat (1) @(negedge clk);
            if (rx_en) begin
                rx_q.push_back(sh);
                rx_t.push_back(t0);
                rx_ok.push_back(ok);
            end
        end
    end

    initial begin
        int          st;
        int          st6;
        int          guard;
        int          lows;
        logic        rdy;
        logic [7:0]  ch;
        logic [63:0] cap;
        logic [63:0] expv;
        logic [7:0]  chars [6];

        bus_idle();
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // ---- Reset: outputs and a write attempted while res=1 ----
        @(negedge clk);
        db_io         = 1'b1;
        db_accessType = MEM_ACCESS_W;
        db_addr       = ADDR_CHAR;
        db_dataOut    = 32'h55;
        #1;
        check("rst_ready", db_ready, 1);
        @(posedge clk);
        #1;
        check("rst_no_push", fifo_level, 0);
        bus_idle();
        res = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_hlt", hlt, 0);
        check("rst_dataIn", db_dataIn, 0);

        // ---- Single character 0x41, cycle-exact waveform ----
        ch = 8'h41;
        bus_wr(ADDR_CHAR, {24'h0, ch}, st);
        check("t1_no_stall", st, 0);
        @(posedge clk);                      // pop edge
        cap  = '0;
        expv = '0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            cap[i] = txd;
            if (i / DIV == 0)      expv[i] = 1'b0;
            else if (i / DIV == 9) expv[i] = 1'b1;
            else                   expv[i] = ch[i / DIV - 1];
        end
        check("t1_waveform", cap, expv);
        wait_cycles(2);
        bus_rd(ADDR_STATUS, rdy);
        check("t1_status_idle", db_dataIn, 32'h0000_0001);
        check("t1_level", fifo_level, 0);

        // ---- Back-to-back writes overflowing a 4-deep FIFO ----
        chars[0] = 8'hA5; chars[1] = 8'h3C; chars[2] = 8'h00;
        chars[3] = 8'hFF; chars[4] = 8'h5A; chars[5] = 8'h81;
        rx_q.delete(); rx_t.delete(); rx_ok.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_wr(ADDR_CHAR, {24'h0, chars[i]}, st);
            check($sformatf("t2_stall_c%0d", i), st, 0);
        end
        check("t2_level_full", fifo_level, 4);
        bus_wr(ADDR_CHAR, {24'h0, chars[5]}, st6);
        // stalled from the cycle after the 5th write until the STOP pop edge of frame 1
        check("t2_stall_c5", st6, 37);
        check("t2_level_after", fifo_level, 4);
        guard = 0;
        while (rx_q.size() < 6 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        check("t2_frames", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++) begin
            check($sformatf("t2_char%0d", i), rx_q[i], chars[i]);
            check($sformatf("t2_frame_ok%0d", i), rx_ok[i], 1);
            if (i > 0) check($sformatf("t2_gap%0d", i), rx_t[i] - rx_t[i-1], FRAME);
        end
        rx_en = 1'b0;
        wait_cycles(10);

        // ---- STATUS with two queued and TX busy; unmapped read ----
        bus_wr(ADDR_CHAR, 32'h10, st);
        bus_wr(ADDR_CHAR, 32'h20, st);
        bus_wr(ADDR_CHAR, 32'h30, st);
        bus_rd(ADDR_STATUS, rdy);
        check("t4_status_rdy", rdy, 1);
        check("t4_status", db_dataIn, 32'h0000_0204);
        bus_rd(32'h7, rdy);
        check("t4_unmapped_rdy", rdy, 1);
        check("t4_unmapped_data", db_dataIn, 0);
        wait_cycles(3 * FRAME + 10);
        check("t4_drained", fifo_level, 0);
        check("t4_txd_idle", txd, 1);

        // ---- Halt flag ----
        bus_wr(ADDR_HLT, 32'h0, st);
        check("t3_hlt_set", hlt, 1);
        bus_rd(ADDR_STATUS, rdy);
        check("t3_status_hlt", db_dataIn, 32'h0000_0009);
        bus_wr(ADDR_HLT, 32'h0, st);
        check("t3_hlt_again", hlt, 1);
        check("t3_level", fifo_level, 0);
        pulse_reset();
        check("t3_hlt_clr", hlt, 0);
        check("t3_dataIn_clr", db_dataIn, 0);

        // ---- Ignored accesses ----
        @(negedge clk);
        db_io = 1'b0; db_accessType = MEM_ACCESS_W; db_addr = ADDR_CHAR; db_dataOut = 32'h77;
        #1;
        check("t5_noio_rdy", db_ready, 1);
        @(posedge clk);
        #1;
        check("t5_noio_level", fifo_level, 0);
        @(negedge clk);
        db_io = 1'b1; db_accessType = MEM_ACCESS_X;
        #1;
        check("t5_x_rdy", db_ready, 1);
        @(posedge clk);
        #1;
        bus_idle();
        check("t5_x_level", fifo_level, 0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("t5_txd_quiet", lows, 0);

        // Same accesses while the FIFO is full
        for (int i = 0; i < 5; i++) bus_wr(ADDR_CHAR, 32'h60 + i, st);
        check("t5_full_level", fifo_level, 4);
        bus_rd(ADDR_STATUS, rdy);
        check("t5_full_status", db_dataIn, 32'h0000_0406);
        @(negedge clk);
        db_io = 1'b1; db_accessType = MEM_ACCESS_W; db_addr = ADDR_CHAR;
        #1;
        check("t5_full_w_stall", db_ready, 0);
        db_accessType = MEM_ACCESS_X;
        #1;
        check("t5_full_x_rdy", db_ready, 1);
        db_io = 1'b0; db_accessType = MEM_ACCESS_W;
        #1;
        check("t5_full_noio_rdy", db_ready, 1);
        db_io = 1'b1; db_accessType = MEM_ACCESS_R;
        #1;
        check("t5_full_rd_rdy", db_ready, 1);
        @(posedge clk);
        #1;
        bus_idle();
        check("t5_full_rd_char", db_dataIn, 0);
        pulse_reset();
        check("t5_rst_level", fifo_level, 0);

        // ---- Reset during DATA bit 3 with 3 characters queued ----
        wait_cycles(5);
        bus_wr(ADDR_CHAR, 32'h41, st);
        bus_wr(ADDR_CHAR, 32'h12, st);
        bus_wr(ADDR_CHAR, 32'h34, st);
        bus_wr(ADDR_CHAR, 32'h56, st);
        bus_rd(ADDR_STATUS, rdy);
        check("t6_status", db_dataIn, 32'h0000_0304);
        wait_cycles(14);                     // frame offset 17: DATA bit 3 of 0x41
        check("t6_in_bit3", txd, 0);
        pulse_reset();
        check("t6_txd", txd, 1);
        check("t6_level", fifo_level, 0);
        check("t6_dataIn", db_dataIn, 0);
        bus_rd(ADDR_STATUS, rdy);
        check("t6_status_idle", db_dataIn, 32'h0000_0001);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("t6_no_frames", lows, 0);
        check("t6_level_end", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_uart_console.md
Name: io_uart_console

Overview:
Memory-mapped I/O console that sits directly downstream of CPU_MMU on the data bus. It services every cycle with db_io=1 and replaces the simulation-only halt/print device with synthesizable hardware. Characters written to the console port are buffered in a FIFO and serialized on a UART TX line (8N1). A sticky halt flag and a readable status register are also provided.

Parameters:
FIFO_DEPTH, 16, character FIFO entries; must be a power of two, at least 2.
CLK_DIV, 868, clk cycles per UART bit; must be at least 2.

Ports:
clk  input  1  system clock; all logic on posedge.
res  input  1  synchronous, active-high reset.
db_io  input  1  current bus access targets I/O space.
db_accessType  input  `MEM_ACCESS  access type, encoded per DataBus.vh.
db_addr  input  32  I/O register address.
db_dataOut  input  32  write data from the CPU.
db_dataIn  output  32  read data to the CPU.
db_ready  output  1  access accepted this cycle; 0 stalls the CPU.
hlt  output  1  sticky halt request.
txd  output  1  UART serial output; idles high.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Bus access qualification:
- "sel" means db_io=1 and the access type is `MEM_ACCESS_R or `MEM_ACCESS_W.
- Any other access type, or db_io=0, is ignored and gives db_ready=1.

Register map (db_addr compared on all 32 bits):
- 0x0, HLT, write-only: a write sets hlt=1. hlt stays 1 until res.
- 0x1, CHAR, write-only: a write pushes db_dataOut[7:0] into the FIFO.
- 0x2, STATUS, read-only:
  - bit 0: fifo_empty
  - bit 1: fifo_full
  - bit 2: tx_busy (FSM not IDLE)
  - bit 3: hlt
  - bits [15:8]: fifo_level
  - all other bits 0
- Writes to STATUS, reads of HLT or CHAR, and any unmapped address: no effect, db_ready=1, read returns 0.

db_ready:
- Combinational.
- 0 only when sel, W, addr 0x1, and fifo_full=1. Otherwise 1.
- A stalled write is retried each cycle. It is accepted on the first edge where fifo_full=0 at the start of the cycle.
- A TX pop in the same cycle does not unblock that cycle's write.

db_dataIn:
- Registered. On the edge where a read is accepted, db_dataIn loads the selected value. It holds until the next accepted read.
- Reset value 0.

FIFO:
- Circular buffer with wrapping rd/wr pointers and a (log2+1)-bit count.
- A push when not full and a pop in the same cycle leaves count unchanged, and both pointers advance.
- A pop only occurs when not empty.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1. If FIFO is not empty, pop the head into the shift register and go to START.
- START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
- DATA: txd=shift[0] for CLK_DIV cycles per bit, LSB first. After 8 bits go to STOP.
- STOP: txd=1 for CLK_DIV cycles. Then, if FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..CLK_DIV-1 and restarts on every state or bit change.
- A frame is exactly 10*CLK_DIV cycles.
- The first START cycle is the cycle after the pop edge.
- txd is registered.

Reset (synchronous, any time, including mid-frame):
- Next edge: hlt=0, txd=1, state IDLE, FIFO empty (fifo_level=0), db_dataIn=0, baud counter 0.
- Queued characters are discarded. A partial frame is truncated, not completed.
- While res=1, bus accesses are ignored and db_ready=1.

Test Plan:
1. CLK_DIV=4. Write 0x41 to addr 0x1 with W, db_io=1 -> db_ready=1. txd then shows 0, bits 1,0,0,0,0,0,1,0, then 1, each bit held 4 cycles (40 cycles total). Afterwards tx_busy=0 and fifo_level=0.
2. FIFO_DEPTH=4, CLK_DIV=4. Write 6 chars back-to-back -> first char popped to TX, next 4 fill the FIFO, and the 6th write sees db_ready=0 until the first frame ends. It is accepted on the cycle after STOP pops. All 6 chars appear on txd in order with no idle gap.
3. Write 0x0 -> hlt=1 on the next edge and STATUS bit 3 = 1. A further write of 0x0 changes nothing. res=1 for one cycle -> hlt=0.
4. Read 0x2 with two chars queued and TX busy -> db_dataIn=0x00000204 (bit 2 set, level 2) after the edge. A read of 0x7 returns 0 with db_ready=1.
5. An access with db_io=0 to addr 0x1 (W), and an `MEM_ACCESS_X access with db_io=1 -> no FIFO push, db_ready=1, txd stays 1.
6. Assert res during DATA bit 3 with 3 chars queued -> the next edge gives txd=1, fifo_level=0, state IDLE, and no further frames are sent.
